// File: rtl/multi_digit_counter_display_if.sv
// Pin-side bundle for multi_digit_counter_display: raw buttons and switches
// in, multiplexed seven-segment drives and the packed BCD count out.
// master = board/bench side, slave = counter/display block.
interface multi_digit_counter_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    increment;
  logic                    decrement;
  logic                    mode_select;
  logic                    count_down;
  logic [NUM_DIGITS-1:0]   digit_select;
  logic [6:0]              seven;
  logic [4*NUM_DIGITS-1:0] count_value;
  logic                    carry_out;

  modport master (
    output increment, decrement, mode_select, count_down,
    input  digit_select, seven, count_value, carry_out
  );

  modport slave (
    input  increment, decrement, mode_select, count_down,
    output digit_select, seven, count_value, carry_out
  );
endinterface

// File: rtl/multi_digit_counter_display.sv
// N-digit BCD up/down counter with per-button debounce, manual/auto mode and
// a multiplexed active-low seven-segment scan driver.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank every digit above
// the highest non-zero digit (digit 0 is always shown).
module multi_digit_counter_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int TICK_DIV     = 100000000,
  parameter int DEBOUNCE_MAX = 1000000
) (
  input logic                          clk_100mhz,
  input logic                          reset_n,
  multi_digit_counter_display_if.slave bus
);
  localparam int CNT_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DB_W   = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX) : 1;

  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MAX - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [3:0]            sync_1, sync_2;
  logic [1:0]            btn_s;
  logic                  auto_s, down_s;
  logic [1:0]            db_stable, db_stable_d, press;
  logic [DB_W-1:0]       db_cnt [2];
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;
  logic                  step_en, step_up;
  logic [CNT_W-1:0]      count_q, count_next;
  logic                  wrap, carry_q;
  logic [REF_W-1:0]      ref_cnt;
  logic                  refresh;
  logic [IDX_W-1:0]      scan_idx, idx_next;
  logic                  lit_q;
  logic [NUM_DIGITS-1:0] blank, anode_next, digit_sel_q;
  logic [3:0]            digit_val;
  logic                  digit_blank;
  logic [6:0]            seven_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    seg_decode = 7'b1111111;
    case (d)
      4'd0: seg_decode = 7'b1000000;
      4'd1: seg_decode = 7'b1111001;
      4'd2: seg_decode = 7'b0100100;
      4'd3: seg_decode = 7'b0110000;
      4'd4: seg_decode = 7'b0011001;
      4'd5: seg_decode = 7'b0010010;
      4'd6: seg_decode = 7'b0000010;
      4'd7: seg_decode = 7'b1111000;
      4'd8: seg_decode = 7'b0000000;
      4'd9: seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Two-flop synchronisers for every asynchronous board input.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {bus.count_down, bus.mode_select, bus.decrement, bus.increment};
      sync_2 <= sync_1;
    end
  end

  assign btn_s  = sync_2[1:0];
  assign auto_s = sync_2[2];
  assign down_s = sync_2[3];

  // Debounce both buttons; a level only flips after DEBOUNCE_MAX differing
  // cycles in a row, and only its rising edge yields a press pulse.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      db_stable   <= '0;
      db_stable_d <= '0;
      press       <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == db_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_stable[i] <= ~db_stable[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      db_stable_d <= db_stable;
      press       <= db_stable & ~db_stable_d;
    end
  end

  // Auto-mode step timer, parked at zero in manual mode so the first auto
  // step lands a full period after entering auto mode.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n)                         tick_cnt <= '0;
    else if (!auto_s || tick == 1'b1)     tick_cnt <= '0;
    else                                  tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = auto_s && (tick_cnt == TICK_LAST);

  // Choose whether and which way to step; simultaneous manual presses cancel.
  always_comb begin
    step_en = 1'b0;
    step_up = 1'b1;
    if (auto_s) begin
      step_en = tick;
      step_up = !down_s;
    end else begin
      step_en = press[0] ^ press[1];
      step_up = press[0];
    end
  end

  // Ripple BCD increment/decrement; wrap is the carry/borrow out of the top digit.
  always_comb begin
    count_next = count_q;
    wrap       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wrap) begin
        if (step_up) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_next[4*i +: 4] = 4'd0;
          end else begin
            count_next[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            wrap = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            count_next[4*i +: 4] = 4'd9;
          end else begin
            count_next[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            wrap = 1'b0;
          end
        end
      end
    end
  end

  // Count register and one-cycle carry/borrow pulse.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      carry_q <= step_en & wrap;
      if (step_en) count_q <= count_next;
    end
  end

  // Free-running scan-step divider.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n)     ref_cnt <= '0;
    else if (refresh) ref_cnt <= '0;
    else              ref_cnt <= ref_cnt + 1'b1;
  end

  assign refresh = (ref_cnt == REF_LAST);

  // Next scan position, used for both the index and the display registers
  // so anode and segments always move together.
  always_comb begin
    idx_next = scan_idx;
    if (refresh) idx_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
  end

  // Scan index; lit_q keeps the display dark until the first refresh strobe.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx <= IDX_LAST;
      lit_q    <= 1'b0;
    end else begin
      scan_idx <= idx_next;
      lit_q    <= lit_q | refresh;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Blank digits that sit above the highest non-zero digit; digit 0 never blanks.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  // Select the digit and anode pattern for the upcoming scan position.
  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    anode_next  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        digit_val     = count_q[4*i +: 4];
        digit_blank   = blank[i];
        anode_next[i] = 1'b0;
      end
    end
  end

  // Registered display drives; segments follow count changes one edge later.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      digit_sel_q <= '1;
      seven_q     <= 7'b1111111;
    end else if (lit_q || refresh) begin
      digit_sel_q <= anode_next;
      seven_q     <= digit_blank ? 7'b1111111 : seg_decode(digit_val);
    end
  end

  assign bus.count_value  = count_q;
  assign bus.carry_out    = carry_q;
  assign bus.digit_select = digit_sel_q;
  assign bus.seven        = seven_q;
endmodule
